// File: rtl/trigger_handshake_if.sv
// Trigger handshake port bundle: debounced input level, AVR req/ack pair and status.
// Latency: none, wires only.
// Backpressure: carried by the trig_out/avr_ack four-phase handshake.
interface trigger_handshake_if #(
  parameter int CNT_W = 8
);
  logic             input_in;
  logic             avr_ack;
  logic             trig_out;
  logic [CNT_W-1:0] event_count;
  logic [3:0]       pending;
  logic             timeout_err;

  // Trigger block side: samples the level and ack, drives request and status.
  modport master (
    input  input_in,
    input  avr_ack,
    output trig_out,
    output event_count,
    output pending,
    output timeout_err
  );

  // Environment / AVR side.
  modport slave (
    output input_in,
    output avr_ack,
    input  trig_out,
    input  event_count,
    input  pending,
    input  timeout_err
  );
endinterface

// File: rtl/trigger_handshake.sv
// Debounces an async level, counts rising edges, and issues one AVR trigger per event.
// Latency: trig_out rises DEB_CYCLES+2 edges after input_in is first sampled high (FSM idle).
// Backpressure: events queue in a saturating 4-bit pending count while a handshake is open.
module trigger_handshake #(
  parameter int DEB_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1000,
  parameter int CNT_W       = 8
) (
  input logic                clk,
  input logic                reset,
  trigger_handshake_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam logic [7:0]  DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] TIMER_END = 16'(ACK_TIMEOUT - 1);
  localparam logic [3:0]  PEND_MAX  = 4'd15;

  logic             in_meta;
  logic             in_s;
  logic             ack_meta;
  logic             ack_s;
  logic             stable;
  logic [7:0]       deb_cnt;
  logic             deb_hit;
  logic             event_pulse;
  logic [CNT_W-1:0] event_count_q;
  logic [3:0]       pending_q;
  logic [15:0]      timer;
  logic             timeout_hit;
  state_t           state;
  state_t           state_nxt;
  logic             dequeue;
  logic             timer_clr;
  logic             err_set;
  logic             trig_q;
  logic             err_q;

  // Two-flop synchronizers: the only logic that looks at the raw pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_meta  <= 1'b0;
      in_s     <= 1'b0;
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      in_meta  <= bus.input_in;
      in_s     <= in_meta;
      ack_meta <= bus.avr_ack;
      ack_s    <= ack_meta;
    end
  end

  // A level change is accepted on the DEB_CYCLES-th consecutive differing sample.
  assign deb_hit     = (in_s != stable) && (deb_cnt == DEB_LAST);
  assign event_pulse = deb_hit && in_s;

  // Debounce counter and accepted stable level.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable  <= 1'b0;
      deb_cnt <= 8'd0;
    end else if (in_s == stable) begin
      deb_cnt <= 8'd0;
    end else if (deb_hit) begin
      stable  <= in_s;
      deb_cnt <= 8'd0;
    end else begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  end

  // Total accepted rising edges, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_count_q <= '0;
    end else if (event_pulse) begin
      event_count_q <= event_count_q + 1'b1;
    end
  end

  // Pending queue depth: saturating increment, decrement on dequeue, both cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 4'd0;
    end else begin
      case ({event_pulse, dequeue})
        2'b10:   if (pending_q != PEND_MAX) pending_q <= pending_q + 4'd1;
        2'b01:   pending_q <= pending_q - 4'd1;
        default: pending_q <= pending_q;
      endcase
    end
  end

  assign timeout_hit = (timer == TIMER_END);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: an ack transition always wins over a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pending_q != 4'd0) state_nxt = REQ;
      REQ:      if (ack_s) state_nxt = WAIT_REL;
                else if (timeout_hit) state_nxt = IDLE;
      WAIT_REL: if (!ack_s) state_nxt = IDLE;
                else if (timeout_hit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM outputs: dequeue on leaving IDLE, timer restart on any state change, error on timeout.
  always_comb begin
    dequeue   = (state == IDLE) && (pending_q != 4'd0);
    timer_clr = (state_nxt != state);
    err_set   = timeout_hit &&
                (((state == REQ) && !ack_s) || ((state == WAIT_REL) && ack_s));
  end

  // Handshake timer, counting only while a handshake is open.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= 16'd0;
    end else if (timer_clr) begin
      timer <= 16'd0;
    end else if (state != IDLE) begin
      timer <= timer + 16'd1;
    end
  end

  // Registered trigger (glitch-free) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      trig_q <= (state_nxt == REQ);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.trig_out    = trig_q;
  assign bus.event_count = event_count_q;
  assign bus.pending     = pending_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_trigger_handshake.sv
// Bench for trigger_handshake: event-level model plus directed scenarios.
// Latency: model predicts outputs every cycle.
// Backpressure: AVR ack emulated as held-low, held-high or delayed loopback.
module tb_trigger_handshake;
  localparam int DEB = 4;
  localparam int AT0 = 10;
  localparam int AT1 = 1000;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic in_drv = 1'b0;
  logic ack_drv = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   ack_mode = 0;

  trigger_handshake_if #(.CNT_W(8)) bus0 ();
  trigger_handshake_if #(.CNT_W(8)) bus1 ();

  assign bus0.input_in = in_drv;
  assign bus0.avr_ack  = ack_drv;
  assign bus1.input_in = in_drv;
  assign bus1.avr_ack  = 1'b1;

  trigger_handshake #(.DEB_CYCLES(DEB), .ACK_TIMEOUT(AT0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus0));

  // Second instance: long timeout and ack stuck high, used to reach pending saturation.
  trigger_handshake #(.DEB_CYCLES(DEB), .ACK_TIMEOUT(AT1), .CNT_W(8)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sync pipeline as two sample slots; debounce as "edges since in_s last agreed";
  // queue as a clamped integer; handshake as a phase with an entry timestamp.
  bit m_a1[2], m_a2[2], m_b1[2], m_b2[2], m_stable[2], m_trig[2], m_err[2];
  int m_agree[2], m_phase[2], m_t[2], m_pend[2], m_cnt[2];

  task automatic model_step(input int i, input int at, input bit inp, input bit ack, input bit rst);
    bit ins, acks, ev, deq;
    int p;
    if (rst) begin
      m_a1[i] = 0; m_a2[i] = 0; m_b1[i] = 0; m_b2[i] = 0;
      m_stable[i] = 0; m_trig[i] = 0; m_err[i] = 0;
      m_agree[i] = cyc; m_phase[i] = 0; m_t[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
    end else begin
      ins  = m_a2[i];
      acks = m_b2[i];
      ev   = 0;
      if (ins == m_stable[i]) m_agree[i] = cyc;
      else if (cyc - m_agree[i] >= DEB) begin
        m_stable[i] = ins;
        m_agree[i]  = cyc;
        ev          = ins;
      end
      deq = (m_phase[i] == 0) && (m_pend[i] > 0);
      case (m_phase[i])
        0: if (m_pend[i] > 0) begin m_phase[i] = 1; m_t[i] = cyc; end
        1: if (acks) begin m_phase[i] = 2; m_t[i] = cyc; end
           else if (cyc - m_t[i] == at) begin m_phase[i] = 0; m_err[i] = 1; end
        default: if (!acks) m_phase[i] = 0;
           else if (cyc - m_t[i] == at) begin m_phase[i] = 0; m_err[i] = 1; end
      endcase
      p = m_pend[i] + int'(ev) - int'(deq);
      m_pend[i] = (p > 15) ? 15 : p;
      m_cnt[i]  = m_cnt[i] + int'(ev);
      m_trig[i] = (m_phase[i] == 1);
      m_a2[i] = m_a1[i]; m_a1[i] = inp;
      m_b2[i] = m_b1[i]; m_b1[i] = ack;
    end
  endtask

  // Model advances on every rising edge using the inputs the DUT sampled.
  always @(posedge clk) begin
    model_step(0, AT0, in_drv, ack_drv, reset);
    model_step(1, AT1, in_drv, 1'b1, reset);
    cyc++;
  end

  // Compare both instances against the model shortly after each rising edge.
  initial begin
    @(posedge clk);
    forever begin
      #1;
      chk("m0_trig",  bus0.trig_out,    m_trig[0]);
      chk("m0_count", bus0.event_count, m_cnt[0] % 256);
      chk("m0_pend",  bus0.pending,     m_pend[0]);
      chk("m0_err",   bus0.timeout_err, m_err[0]);
      chk("m1_trig",  bus1.trig_out,    m_trig[1]);
      chk("m1_count", bus1.event_count, m_cnt[1] % 256);
      chk("m1_pend",  bus1.pending,     m_pend[1]);
      chk("m1_err",   bus1.timeout_err, m_err[1]);
      @(posedge clk);
    end
  end

  // AVR emulation: ack held low, held high, or trig_out looped back three cycles late.
  initial begin
    bit d0, d1, d2;
    d0 = 0; d1 = 0; d2 = 0;
    forever begin
      @(negedge clk);
      case (ack_mode)
        0: ack_drv = 1'b0;
        1: ack_drv = 1'b1;
        default: begin
          ack_drv = d2; d2 = d1; d1 = d0; d0 = bus0.trig_out;
        end
      endcase
    end
  end

  // Global watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    chk({tag, "_rst_trig"},  bus0.trig_out,    0);
    chk({tag, "_rst_pend"},  bus0.pending,     0);
    chk({tag, "_rst_count"}, bus0.event_count, 0);
    chk({tag, "_rst_err"},   bus0.timeout_err, 0);
    reset = 1'b0;
  endtask

  task automatic edges(input int n, input int half);
    repeat (n) begin
      in_drv = 1'b1; tick(half);
      in_drv = 1'b0; tick(half);
    end
  endtask

  initial begin
    int n, hi, k;
    bit saw, found;

    // Clean edge with loopback ack: trig rises on edge k+6.
    ack_mode = 2; in_drv = 0;
    do_reset("t1");
    tick(3);
    in_drv = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!bus0.trig_out && n < 40);
    chk("t1_trig_edge", n, 7);
    tick(40);
    chk("t1_count", bus0.event_count, 1);
    chk("t1_pend",  bus0.pending, 0);
    chk("t1_trig",  bus0.trig_out, 0);
    chk("t1_err",   bus0.timeout_err, 0);

    // Three-cycle glitch is rejected.
    in_drv = 0;
    do_reset("t2");
    tick(3);
    saw = 0;
    in_drv = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (i == 3) in_drv = 1'b0;
      tick(1);
      if (bus0.trig_out) saw = 1;
    end
    chk("t2_count", bus0.event_count, 0);
    chk("t2_trig_seen", saw, 0);

    // Ack never comes: trig high exactly ten cycles, sticky error.
    ack_mode = 0;
    do_reset("t3");
    tick(2);
    in_drv = 1'b1;
    n = 0;
    while (!bus0.trig_out && n < 30) begin tick(1); n++; end
    chk("t3_trig_rose", bus0.trig_out, 1);
    hi = 0;
    while (bus0.trig_out && hi < 100) begin hi++; tick(1); end
    chk("t3_trig_len", hi, 10);
    chk("t3_err", bus0.timeout_err, 1);
    tick(50);
    chk("t3_err_sticky", bus0.timeout_err, 1);
    in_drv = 1'b0;
    do_reset("t3b");

    // Ack stuck high: 18 edges, pending saturates on the long-timeout instance.
    ack_mode = 1;
    tick(2);
    edges(18, 5);
    tick(10);
    chk("t4_count0", bus0.event_count, 18);
    chk("t4_count1", bus1.event_count, 18);
    chk("t4_pend1",  bus1.pending, 15);

    // 257 edges with loopback ack: count wraps to 1.
    ack_mode = 2;
    do_reset("t5");
    tick(2);
    edges(257, 5);
    tick(60);
    chk("t5_wrap", bus0.event_count, 1);

    // Reset while in REQ with three events queued.
    ack_mode = 0;
    do_reset("t6");
    found = 0;
    k = 0;
    for (int i = 0; i < 800; i++) begin
      if (bus0.trig_out && bus0.pending == 3) begin found = 1; break; end
      k++;
      in_drv = ((k >> 2) & 1) != 0;
      tick(1);
    end
    chk("t6_reached_req_p3", found, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_trig",  bus0.trig_out, 0);
    chk("t6_pend",  bus0.pending, 0);
    chk("t6_count", bus0.event_count, 0);
    chk("t6_err",   bus0.timeout_err, 0);
    @(negedge clk);

    // Input already high at reset release is counted.
    in_drv = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(12);
    chk("t7_count", bus0.event_count, 1);
    in_drv = 1'b0;
    tick(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
